apb_slave_regbank: RTL

// - APB completer (responder) for the APB agent bus: answers one psel bit with a

---
 rtl/apb_slave_pkg.sv | 20 ++
 rtl/apb_slave_regfile.sv | 46 ++++
 rtl/apb_slave_regbank.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-bank completer.
// Holds the FSM state encoding, the response codes and the word-index decode.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic APB_OK  = 1'b0;
    localparam logic APB_ERR = 1'b1;

    // Word index of a byte address, widened so any bus width compares exactly.
    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return {2'b00, addr[63:2]};
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Register storage for the APB completer: one write port, a read mux,
// and a read-only identification word at index 0.
module apb_slave_regfile #(
    parameter int                NUM_REGS = 8,
    parameter int                DATA_W   = 32,
    parameter int                IDX_W    = 3,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    // Index 0 has no storage; it always reads back ID_VALUE.
    logic [DATA_W-1:0] store [1:NUM_REGS-1];

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (srst) begin
                    store[gi] <= '0;
                end else if (we && (waddr == IDX_W'(gi))) begin
                    store[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (raddr == '0) begin
            rdata = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr == IDX_W'(i)) begin
                rdata = store[i];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer answering one psel bit with a bank of 32-bit registers,
// a fixed number of wait states and pslverr on illegal accesses.
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int                     PADDR_WIDTH = 32,
    parameter int                     PDATA_WIDTH = 32,
    parameter int                     PSEL_IDX    = 0,
    parameter int                     NUM_REGS    = 8,
    parameter int                     WAIT_CYCLES = 0,
    parameter logic [PDATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                   pclock,
    input  logic                   preset,
    input  logic [PADDR_WIDTH-1:0] paddr,
    input  logic                   prwd,
    input  logic [PDATA_WIDTH-1:0] pwdata,
    input  logic                   penable,
    input  logic [15:0]            psel,
    output logic [PDATA_WIDTH-1:0] prdata,
    output logic                   pready,
    output logic                   pslverr
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                 state_reg;
    state_t                 state_next;
    state_t                 phase;
    logic [3:0]             waitcnt_reg;
    logic [3:0]             waitcnt_next;
    logic [PADDR_WIDTH-1:0] addr_reg;
    logic                   write_reg;
    logic [PDATA_WIDTH-1:0] wdata_reg;
    logic                   pready_reg;
    logic                   pslverr_reg;
    logic [PDATA_WIDTH-1:0] prdata_reg;

    logic                   sel;
    logic [PADDR_WIDTH-1:0] xfer_addr;
    logic                   xfer_write;
    logic [63:0]            xfer_index;
    logic                   xfer_err;
    logic [IDX_W-1:0]       reg_idx;
    logic [PDATA_WIDTH-1:0] rd_data;
    logic                   commit;
    logic                   enter_done;
    logic                   unused_psel;

    assign sel         = psel[PSEL_IDX];
    assign unused_psel = ^psel;

    // The setup cycle itself is decoded combinationally as SETUP, so its
    // decision is taken on the edge that starts access cycle 1; that is what
    // lets pready land in access cycle 1+WAIT_CYCLES with registered outputs.
    always_comb begin
        phase = state_reg;
        if (((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && sel && !penable) begin
            phase = ST_SETUP;
        end
    end

    // During SETUP the bus carries the transfer; afterwards the latched copy does.
    assign xfer_addr  = (phase == ST_SETUP) ? paddr : addr_reg;
    assign xfer_write = (phase == ST_SETUP) ? prwd  : write_reg;
    assign xfer_index = word_index(64'(xfer_addr));
    assign xfer_err   = (xfer_index >= 64'(NUM_REGS))
                     || (xfer_addr[1:0] != 2'b00)
                     || (xfer_write && (xfer_index == 64'd0));
    assign reg_idx    = xfer_index[IDX_W-1:0];

    always_comb begin
        state_next   = phase;
        waitcnt_next = waitcnt_reg;
        commit       = 1'b0;
        case (phase)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_SETUP: begin
                waitcnt_next = 4'(WAIT_CYCLES);
                state_next   = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_next = ST_IDLE;
                end else begin
                    waitcnt_next = waitcnt_reg - 4'd1;
                    if (waitcnt_reg <= 4'd1) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                commit     = sel && penable && write_reg && !xfer_err;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign enter_done = (state_next == ST_DONE);

    always_ff @(posedge pclock) begin
        if (preset) begin
            state_reg   <= ST_IDLE;
            waitcnt_reg <= '0;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            wdata_reg   <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= APB_OK;
            prdata_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            waitcnt_reg <= waitcnt_next;
            if (phase == ST_SETUP) begin
                addr_reg  <= paddr;
                write_reg <= prwd;
                wdata_reg <= pwdata;
            end
            pready_reg  <= enter_done;
            pslverr_reg <= (enter_done && xfer_err) ? APB_ERR : APB_OK;
            prdata_reg  <= (enter_done && !xfer_err && !xfer_write) ? rd_data : '0;
        end
    end

    assign pready  = pready_reg;
    assign pslverr = pslverr_reg;
    assign prdata  = prdata_reg;

    apb_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (PDATA_WIDTH),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk   (pclock),
        .srst  (preset),
        .we    (commit),
        .waddr (reg_idx),
        .wdata (wdata_reg),
        .raddr (reg_idx),
        .rdata (rd_data)
    );

endmodule
